// File: rtl/sin_dds_gen.sv
// rtl/sin_dds_gen.sv - phase-accumulator sine source with quarter-wave ROM
// Three-stage pipeline (phase/decode, ROM read, sign apply); hsync/vsync travel with the samples.
module sin_dds_gen #(
  parameter int OUT_W   = 12,
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 6
) (
  input  logic               clkin,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic               inc_load,
  input  logic [PHASE_W-1:0] phase_off,
  output logic [OUT_W-1:0]   sin_x,
  output logic               valid,
  output logic               hsync,
  output logic               vsync
);
  localparam int TW    = LUT_AW + 2;
  localparam int SH    = PHASE_W - TW;
  localparam int DEPTH = 1 << LUT_AW;

  // Half-step sample points keep the table symmetric and clear of the negative full-scale code.
  function automatic logic [OUT_W-1:0] lut_entry(input int i);
    real peak;
    real ang;
    peak = (2.0 ** (OUT_W - 1)) - 1.0;
    ang  = 1.5707963267948966 * (real'(i) + 0.5) / real'(DEPTH);
    return OUT_W'($rtoi(peak * $sin(ang) + 0.5));
  endfunction

  logic [OUT_W-1:0] rom [DEPTH];
  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam logic [OUT_W-1:0] ENTRY = lut_entry(g);
    assign rom[g] = ENTRY;
  end

  logic [PHASE_W-1:0] acc_q, acc_d, inc_q;
  logic               wrap_q, wrap_d, first_q;
  logic               v1_q, hs1_q;
  logic [TW-1:0]      ph1_q, p_top_d;
  logic               v2_q, hs2_q, neg2_q;
  logic [OUT_W-1:0]   mag2_q;
  logic [OUT_W-1:0]   sin_x_q;
  logic               valid_q, hsync_q;
  logic [1:0]         quad;
  logic [LUT_AW-1:0]  addr, addr_m;

  assign {wrap_d, acc_d} = {1'b0, acc_q} + {1'b0, inc_q};

  // Only quadrant and address bits are kept; the truncated low half contributes just its carry.
  if (SH > 0) begin : g_carry
    logic lo_carry;
    assign lo_carry = acc_q[SH-1:0] > ~phase_off[SH-1:0];
    assign p_top_d  = acc_q[PHASE_W-1:SH] + phase_off[PHASE_W-1:SH] + TW'(lo_carry);
  end else begin : g_nocarry
    assign p_top_d = acc_q + phase_off;
  end

  assign quad   = ph1_q[TW-1:TW-2];
  assign addr   = ph1_q[LUT_AW-1:0];
  assign addr_m = quad[0] ? ~addr : addr;

  always_ff @(posedge clkin) begin
    if (rst) begin
      acc_q   <= '0;
      inc_q   <= '0;
      wrap_q  <= 1'b0;
      first_q <= 1'b1;
      v1_q    <= 1'b0;
      hs1_q   <= 1'b0;
      ph1_q   <= '0;
      v2_q    <= 1'b0;
      hs2_q   <= 1'b0;
      neg2_q  <= 1'b0;
      mag2_q  <= '0;
      sin_x_q <= '0;
      valid_q <= 1'b0;
      hsync_q <= 1'b0;
    end else begin
      if (inc_load) inc_q <= phase_inc;
      if (en) begin
        acc_q   <= acc_d;
        wrap_q  <= wrap_d;
        first_q <= 1'b0;
        ph1_q   <= p_top_d;
        hs1_q   <= first_q | wrap_q;
      end
      v1_q    <= en;
      v2_q    <= v1_q;
      hs2_q   <= hs1_q;
      neg2_q  <= quad[1];
      mag2_q  <= rom[addr_m];
      valid_q <= v2_q;
      hsync_q <= v2_q & hs2_q;
      if (v2_q) sin_x_q <= neg2_q ? -mag2_q : mag2_q;
    end
  end

  assign sin_x = sin_x_q;
  assign valid = valid_q;
  assign hsync = hsync_q;
  assign vsync = ~(v1_q | v2_q | valid_q);

endmodule

// File: tb/tb_sin_dds_gen.sv
// tb/tb_sin_dds_gen.sv - scoreboard bench for sin_dds_gen
module tb_sin_dds_gen;
  logic        clkin = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        inc_load = 1'b0;
  logic [15:0] phase_inc = '0;
  logic [15:0] phase_off = '0;
  logic [11:0] sin_x;
  logic        valid, hsync, vsync;

  sin_dds_gen #(.OUT_W(12), .PHASE_W(16), .LUT_AW(6)) dut (
    .clkin(clkin), .rst(rst), .en(en), .phase_inc(phase_inc), .inc_load(inc_load),
    .phase_off(phase_off), .sin_x(sin_x), .valid(valid), .hsync(hsync), .vsync(vsync)
  );

  always #5 clkin = ~clkin;

  typedef struct packed {
    logic [11:0] s;
    logic        h;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [11:0] obs_s[$];
  logic        obs_h[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] m_acc = '0;
  logic [15:0] m_inc = '0;
  logic        m_wrap = 1'b0;
  logic        m_first = 1'b1;
  logic [2:0]  hist = '0;
  logic        mon_en = 1'b0;
  logic        rst_q = 1'b0;
  logic [11:0] last_s = '0;

  function automatic logic [11:0] lut(input int i);
    real v;
    v = 2047.0 * $sin(3.141592653589793 / 2.0 * (real'(i) + 0.5) / 64.0);
    return 12'($rtoi(v + 0.5));
  endfunction

  function automatic logic [11:0] exp_sample(input logic [15:0] p);
    logic [5:0]  a;
    logic [11:0] m;
    a = p[13:8];
    if (p[14]) a = ~a;
    m = lut(int'(a));
    return p[15] ? -m : m;
  endfunction

  task automatic cycle(input logic ev, input logic ld, input logic [15:0] inc, input logic [15:0] off);
    logic [16:0] sum;
    en = ev; inc_load = ld; phase_inc = inc; phase_off = off;
    @(posedge clkin);
    hist = {hist[1:0], ev};
    if (ev) begin
      sb.push_back('{s: exp_sample(16'(m_acc + off)), h: m_first | m_wrap});
      sum = {1'b0, m_acc} + {1'b0, m_inc};
      m_acc = sum[15:0]; m_wrap = sum[16]; m_first = 1'b0;
    end
    if (ld) m_inc = inc;
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; en = 1'b0; inc_load = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clkin);
      hist = '0; sb.delete(); m_acc = '0; m_inc = '0; m_wrap = 1'b0; m_first = 1'b1; mon_en = 1'b1;
    end
    #1;
    rst = 1'b0;
  endtask

  always @(posedge clkin) rst_q <= rst;

  always @(negedge clkin) begin
    if (mon_en) begin
      if (rst_q) last_s = '0;
      checks++;
      if (valid !== hist[2]) begin
        failures++; $display("FAIL valid: got %b want %b", valid, hist[2]);
      end
      checks++;
      if (vsync !== (hist == 3'b000)) begin
        failures++; $display("FAIL vsync: got %b want %b", vsync, hist == 3'b000);
      end
      if (valid === 1'b1) begin
        obs_s.push_back(sin_x); obs_h.push_back(hsync);
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL scoreboard: got sample %h want none pending", sin_x);
        end else begin
          e = sb.pop_front();
          if (sin_x !== e.s || hsync !== e.h) begin
            failures++; $display("FAIL sample: got %h/%b want %h/%b", sin_x, hsync, e.s, e.h);
          end
          last_s = e.s;
        end
      end else begin
        checks++;
        if (sin_x !== last_s || hsync !== 1'b0) begin
          failures++; $display("FAIL hold: got %h/%b want %h/0", sin_x, hsync, last_s);
        end
      end
    end
  end

  task automatic test_reset();
    do_reset(5);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clkin);
      checks++;
      if (sin_x !== 12'd0 || valid !== 1'b0 || hsync !== 1'b0 || vsync !== 1'b1) begin
        failures++;
        $display("FAIL reset_idle: got %h %b %b %b want 000 0 0 1", sin_x, valid, hsync, vsync);
      end
    end
  endtask

  task automatic test_sweep();
    int hs_cnt;
    obs_s.delete(); obs_h.delete();
    cycle(1'b0, 1'b1, 16'h0100, 16'h0);
    cycle(1'b1, 1'b0, 16'h0, 16'h0);
    cycle(1'b1, 1'b0, 16'h0, 16'h0);
    @(negedge clkin);
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL latency_early: got %b want 0", valid); end
    cycle(1'b1, 1'b0, 16'h0, 16'h0);
    @(negedge clkin);
    checks++;
    if (valid !== 1'b1 || sin_x !== 12'd25 || hsync !== 1'b1) begin
      failures++; $display("FAIL first_sample: got %b %h %b want 1 019 1", valid, sin_x, hsync);
    end
    for (int i = 3; i < 260; i++) cycle(1'b1, 1'b0, 16'h0, 16'h0);
    repeat (4) cycle(1'b0, 1'b0, 16'h0, 16'h0);
    checks++;
    if (obs_s.size() != 260) begin
      failures++; $display("FAIL sweep_count: got %0d want 260", obs_s.size());
    end else begin
      checks++;
      if (obs_s[63] !== 12'd2047) begin failures++; $display("FAIL s63: got %h want 7ff", obs_s[63]); end
      checks++;
      if (obs_s[64] !== 12'd2047) begin failures++; $display("FAIL s64: got %h want 7ff", obs_s[64]); end
      checks++;
      if (obs_s[128] !== 12'hFE7) begin failures++; $display("FAIL s128: got %h want fe7", obs_s[128]); end
      checks++;
      if (obs_s[192] !== 12'h801) begin failures++; $display("FAIL s192: got %h want 801", obs_s[192]); end
      hs_cnt = 0;
      foreach (obs_h[i]) if (obs_h[i] === 1'b1) hs_cnt++;
      checks++;
      if (hs_cnt != 2 || obs_h[256] !== 1'b1) begin
        failures++; $display("FAIL hsync_period: got count %0d h256 %b want 2 1", hs_cnt, obs_h[256]);
      end
    end
  endtask

  task automatic test_offset();
    do_reset(1);
    obs_s.delete(); obs_h.delete();
    cycle(1'b0, 1'b1, 16'h0100, 16'h4000);
    for (int i = 0; i < 66; i++) cycle(1'b1, 1'b0, 16'h0, 16'h4000);
    repeat (4) cycle(1'b0, 1'b0, 16'h0, 16'h4000);
    checks++;
    if (obs_s.size() != 66) begin
      failures++; $display("FAIL offset_count: got %0d want 66", obs_s.size());
    end else begin
      checks++;
      if (obs_s[0] !== 12'd2047 || obs_h[0] !== 1'b1) begin
        failures++; $display("FAIL offset_s0: got %h/%b want 7ff/1", obs_s[0], obs_h[0]);
      end
      checks++;
      if (obs_s[64] !== 12'hFE7) begin failures++; $display("FAIL offset_s64: got %h want fe7", obs_s[64]); end
    end
  endtask

  task automatic test_inc_load();
    do_reset(1);
    obs_s.delete(); obs_h.delete();
    cycle(1'b0, 1'b1, 16'h0100, 16'h0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 16'h0, 16'h0);
    cycle(1'b1, 1'b1, 16'h0200, 16'h0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 16'h0, 16'h0);
    repeat (4) cycle(1'b0, 1'b0, 16'h0, 16'h0);
    checks++;
    if (obs_s.size() != 21) begin
      failures++; $display("FAIL incload_count: got %0d want 21", obs_s.size());
    end else begin
      checks++;
      if (obs_s[11] !== lut(11)) begin failures++; $display("FAIL incload_old: got %h want %h", obs_s[11], lut(11)); end
      checks++;
      if (obs_s[12] !== lut(13) || obs_s[13] !== lut(15)) begin
        failures++; $display("FAIL incload_new: got %h %h want %h %h", obs_s[12], obs_s[13], lut(13), lut(15));
      end
    end
  endtask

  task automatic test_en_toggle();
    do_reset(1);
    cycle(1'b0, 1'b1, 16'h0100, 16'h0);
    cycle(1'b1, 1'b0, 16'h0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0, 16'h0);
    cycle(1'b1, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clkin);
      checks++;
      if (vsync !== (i == 3) || valid !== (i == 2)) begin
        failures++; $display("FAIL drain_%0d: got vsync %b valid %b want %b %b", i, vsync, valid, i == 3, i == 2);
      end
      if (i == 2) begin
        checks++;
        if (sin_x !== lut(1)) begin failures++; $display("FAIL acc_frozen: got %h want %h", sin_x, lut(1)); end
      end
      cycle(1'b0, 1'b0, 16'h0, 16'h0);
    end
  endtask

  task automatic test_reset_midstream();
    int hs_cnt;
    do_reset(1);
    cycle(1'b0, 1'b1, 16'h0100, 16'h1234);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 16'h0, 16'h1234);
    do_reset(1);
    @(negedge clkin);
    checks++;
    if (valid !== 1'b0 || vsync !== 1'b1 || sin_x !== 12'd0) begin
      failures++; $display("FAIL midreset: got %b %b %h want 0 1 000", valid, vsync, sin_x);
    end
    obs_s.delete(); obs_h.delete();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 16'h0, 16'h1234);
    repeat (4) cycle(1'b0, 1'b0, 16'h0, 16'h1234);
    checks++;
    if (obs_s.size() != 6) begin
      failures++; $display("FAIL postreset_count: got %0d want 6", obs_s.size());
    end else begin
      hs_cnt = 0;
      foreach (obs_h[i]) if (obs_h[i] === 1'b1) hs_cnt++;
      checks++;
      if (obs_s[0] !== lut(18) || obs_s[5] !== lut(18) || obs_h[0] !== 1'b1 || hs_cnt != 1) begin
        failures++;
        $display("FAIL postreset: got %h %h h0 %b cnt %0d want %h %h 1 1", obs_s[0], obs_s[5], obs_h[0], hs_cnt, lut(18), lut(18));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_offset();
    test_inc_load();
    test_en_toggle();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
